serial_mag_compare_ctrl: RTL and testbench

Sequencer that compares two WIDTH-bit unsigned operands MSB-first, two bits per clock, using one combinational 2-bit magnitude slice. The slice produces greater, equal and less for a pair. The block sits between a requester issuing start/operands and any logic consuming a registered one-hot greater/equal/less verdict. It terminates early at the first unequal bit pair and reports completion with a single-cycle done pulse.

---
 rtl/serial_mag_compare_ctrl_if.sv | 25 ++
 rtl/serial_mag_compare_ctrl.sv | 90 +++++++++
 tb/tb_serial_mag_compare_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_mag_compare_ctrl_if.sv
// Request/verdict bundle between a requester and serial_mag_compare_ctrl.
// The requester drives start/clr/operands; the comparator returns status and a one-hot verdict.
interface serial_mag_compare_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             AgB;
  logic             AeB;
  logic             AlB;

  modport master (
    output start, clr, a, b,
    input  busy, done, AgB, AeB, AlB
  );

  modport slave (
    input  start, clr, a, b,
    output busy, done, AgB, AeB, AlB
  );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// MSB-first serial magnitude comparator, two bits per clock, with an early exit at the first
// unequal pair and a one-cycle done pulse alongside a registered one-hot verdict.
module serial_mag_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_mag_compare_ctrl_if.slave bus
);

  localparam int unsigned NP   = WIDTH / 2;
  localparam int unsigned IdxW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NP - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_mag_compare_ctrl: WIDTH must be even and >= 2");
  end

  typedef enum logic [0:0] {StIdle, StCmp} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [IdxW-1:0]  idx_q;
  logic             busy_q, done_q;
  logic             agb_q, aeb_q, alb_q;

  logic [1:0] pa, pb;
  logic       sl_gt, sl_eq, sl_lt;

  // Single 2-bit magnitude slice, always looking at the top pair of the shifters.
  always_comb begin
    pa    = a_sh_q[WIDTH-1 -: 2];
    pb    = b_sh_q[WIDTH-1 -: 2];
    sl_gt = (pa > pb);
    sl_eq = (pa == pb);
    sl_lt = (pa < pb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      agb_q   <= 1'b0;
      aeb_q   <= 1'b0;
      alb_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!bus.clr && bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            idx_q   <= IdxLast;
            busy_q  <= 1'b1;
            state_q <= StCmp;
          end
        end
        StCmp: begin
          if (bus.clr) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (!sl_eq || (idx_q == '0)) begin
            agb_q   <= sl_gt;
            aeb_q   <= sl_eq;
            alb_q   <= sl_lt;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            a_sh_q <= {a_sh_q[WIDTH-3:0], 2'b00};
            b_sh_q <= {b_sh_q[WIDTH-3:0], 2'b00};
            idx_q  <= idx_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.AgB  = agb_q;
  assign bus.AeB  = aeb_q;
  assign bus.AlB  = alb_q;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Directed bench for serial_mag_compare_ctrl (WIDTH=8) with hand-computed expectations.
module tb_serial_mag_compare_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  serial_mag_compare_ctrl_if #(.WIDTH(8)) bus ();

  serial_mag_compare_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs {busy, done, AgB, AeB, AlB} so each step checks the full observable state.
  function automatic logic [7:0] st();
    return {3'b000, bus.busy, bus.done, bus.AgB, bus.AeB, bus.AlB};
  endfunction

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    chk("reset", st(), 8'b00000);
    rst_n = 1'b1;

    // Equal operands: four CMP cycles then AeB.
    bus.a = 8'hA5; bus.b = 8'hA5; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk("eq_busy1", st(), 8'b10000);
    step(); chk("eq_busy2", st(), 8'b10000);
    step(); chk("eq_busy3", st(), 8'b10000);
    step(); chk("eq_busy4", st(), 8'b10000);
    step(); chk("eq_done", st(), 8'b01010);
    step(); chk("eq_done_drop", st(), 8'b00010);

    // Early exit at pair 0.
    bus.a = 8'h80; bus.b = 8'h7F; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk("gt_busy", st(), 8'b10010);
    step(); chk("gt_done", st(), 8'b01100);

    // Exit at pair 1, then back-to-back start on the done cycle.
    bus.a = 8'h1C; bus.b = 8'h2C; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk("lt1_busy1", st(), 8'b10100);
    step(); chk("lt1_busy2", st(), 8'b10100);
    step(); chk("lt1_done", st(), 8'b01001);
    bus.a = 8'h34; bus.b = 8'h36; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk("b2b_accept", st(), 8'b10001);
    step(); chk("b2b_busy2", st(), 8'b10001);
    step(); chk("b2b_busy3", st(), 8'b10001);
    step(); chk("b2b_busy4", st(), 8'b10001);
    step(); chk("b2b_done", st(), 8'b01001);

    // Operand changes and start while busy are ignored.
    bus.a = 8'hFF; bus.b = 8'h00; bus.start = 1'b1;
    step();
    bus.a = 8'h00; bus.b = 8'h00; bus.start = 1'b1;
    chk("ign_busy", st(), 8'b10001);
    step(); bus.start = 1'b0;
    chk("ign_done", st(), 8'b01100);
    step(); chk("ign_idle", st(), 8'b00100);

    // clr on the second CMP cycle aborts without done, verdict retained.
    bus.a = 8'h55; bus.b = 8'h55; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk("clr_busy1", st(), 8'b10100);
    step(); chk("clr_busy2", st(), 8'b10100);
    bus.clr = 1'b1;
    step(); bus.clr = 1'b0;
    chk("clr_abort", st(), 8'b00100);
    step(); chk("clr_nodone", st(), 8'b00100);

    // clr beats start in IDLE.
    bus.a = 8'h00; bus.b = 8'h01; bus.clr = 1'b1; bus.start = 1'b1;
    step(); bus.clr = 1'b0; bus.start = 1'b0;
    chk("clr_start", st(), 8'b00100);
    step(); chk("clr_start2", st(), 8'b00100);

    // Asynchronous reset mid-CMP clears everything immediately.
    bus.a = 8'h55; bus.b = 8'h55; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step(); chk("rst_pre", st(), 8'b10100);
    #2; rst_n = 1'b0;
    #1; chk("rst_async", st(), 8'b00000);
    rst_n = 1'b1;
    bus.a = 8'h01; bus.b = 8'h02; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk("post_busy1", st(), 8'b10000);
    step(); chk("post_busy2", st(), 8'b10000);
    step(); chk("post_busy3", st(), 8'b10000);
    step(); chk("post_busy4", st(), 8'b10000);
    step(); chk("post_done", st(), 8'b01001);
    step(); chk("post_idle", st(), 8'b00001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
